// File: rtl/mul_pkg.sv
// Shared definitions for the HI/LO multiply controller: FSM state encoding,
// default operand width and flag bit positions.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_sign_conv.sv
// Sign handling around an unsigned multiplier: turns request operands into
// magnitudes plus a result-sign bit, and re-applies that sign to the product.
module mul_sign_conv #(
  parameter int WIDTH = 16
) (
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   mag_a_o,
  output logic [WIDTH-1:0]   mag_b_o,
  output logic               neg_o,
  input  logic               res_neg_i,
  input  logic [2*WIDTH-1:0] res_i,
  output logic [2*WIDTH-1:0] res_o
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    a_neg;
  logic                    b_neg;

  // Operand magnitudes; the most-negative value negates onto itself, which
  // reads correctly as 2^(WIDTH-1) when treated as unsigned.
  always_comb begin
    a_s     = a_i;
    b_s     = b_i;
    a_neg   = signed_i && (a_s < 0);
    b_neg   = signed_i && (b_s < 0);
    mag_a_o = a_neg ? -a_i : a_i;
    mag_b_o = b_neg ? -b_i : b_i;
    neg_o   = a_neg ^ b_neg;
  end

  // Full-width two's-complement negation of the product when the sign is set.
  always_comb begin
    res_o = res_neg_i ? -res_i : res_i;
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO multiply controller: accepts a request, drives operand magnitudes to an
// external multiplier, waits LATENCY cycles, then presents the signed or
// unsigned product split into hi/lo with zero/overflow flags.
// Optional feature: define MUL_OVF_FLAG_EN to enable the overflow flag (flag[1]).
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_signed,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [1:0]         flag
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [1:0]         flag_q, flag_d;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_req;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               ovf;

  mul_sign_conv #(
    .WIDTH (WIDTH)
  ) u_sign_conv (
    .signed_i  (req_signed),
    .a_i       (req_a),
    .b_i       (req_b),
    .mag_a_o   (mag_a),
    .mag_b_o   (mag_b),
    .neg_o     (neg_req),
    .res_neg_i (neg_q),
    .res_i     (mul_result),
    .res_o     (res)
  );

  assign res_hi = res[2*WIDTH-1:WIDTH];
  assign res_lo = res[WIDTH-1:0];

`ifdef MUL_OVF_FLAG_EN
  logic signed_q;

  // Remember the operand mode so overflow can be judged against the right range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signed_q <= 1'b0;
    end else if (state_q == ST_IDLE && req_valid) begin
      signed_q <= req_signed;
    end
  end

  // Signed results fit when hi is pure sign extension of lo; unsigned when hi is 0.
  always_comb begin
    ovf = signed_q ? (res_hi != {WIDTH{res_lo[WIDTH-1]}}) : (res_hi != '0);
  end
`else
  assign ovf = 1'b0;
`endif

  // Next-state, datapath loads and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    flag_d    = flag_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mul_a_d = mag_a;
          mul_b_d = mag_b;
          neg_d   = neg_req;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          hi_d              = res_hi;
          lo_d              = res_lo;
          flag_d[FLAG_ZERO] = (res == '0);
          flag_d[FLAG_OVF]  = ovf;
          state_d           = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      flag_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flag_q  <= flag_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign flag  = flag_q;

endmodule
